fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the dual-clock FIFO among N_REQ write-clock-domain requesters. It sits directly in front of the FIFO write-pointer/full logic: it consumes the registered full flag, drives the write increment and write data, and tags each accepted beat with its source index. An optional packet-lock mode holds the grant on one requester until its last beat, bounded by a burst-length watchdog.

## Interface
- N_REQ, 4: number of requesters, 1..16, need not be a power of two.
- DATA_W, 8: FIFO data width.
- MAX_BURST, 16: beat limit per locked burst, ≥2; used only in packet-lock mode.
- SRC_W (localparam): max(1, $clog2(N_REQ)).

- i_clk  in  1  write-domain clock.
- i_rst  in  1  reset: asynchronous, active-high.
- i_reqValid  in  N_REQ  per-requester beat valid.
- i_reqData  in  N_REQ*DATA_W  requester r's data in bits [r*DATA_W +: DATA_W].
- i_reqLast  in  N_REQ  last beat of packet; ignored without packet lock.
- o_reqReady  out  N_REQ  per-requester accept, at most one bit high.
- i_full  in  1  registered FIFO full flag from the write-pointer block.
- o_winc  out  1  FIFO write increment, one beat per high cycle.
- o_wdata  out  DATA_W  data of the granted requester.
- o_wsrc  out  SRC_W  index of the granted requester; valid when o_winc=1.
- o_burstErr  out  1  one-cycle pulse: locked burst force-terminated by the watchdog.

## Operation
- Registered state: priority pointer ptr (0..N_REQ-1); lock state {IDLE, LOCK}; locked index; beat counter (width $clog2(MAX_BURST+1)).
- Arbitration: the winner is the first valid requester at or after ptr, wrapping N_REQ-1 -> 0.
- o_reqReady[w] = winner exists && !i_full; all other bits 0. Transfer = i_reqValid[w] && o_reqReady[w]; o_winc = transfer.
- o_wdata/o_wsrc follow the winner combinationally; o_wsrc = 0 when no winner.
- i_full=1: all readies and o_winc are 0, and no state changes.
- Per-beat mode (macro absent): after each transfer, ptr <= (w+1) mod N_REQ.
- Packet-lock mode: states and transitions:
  - IDLE: arbitrate as above. On a transfer with i_reqLast[w]=0, go to LOCK, latch w, and set count=1. On a transfer with last=1, stay IDLE and advance ptr to w+1.
  - LOCK: only the locked index can win. Other requesters see ready=0 even if valid. On each transfer, count increments.
  - LOCK exit on last=1: go to IDLE, ptr <= locked+1, count <= 0.
  - LOCK exit on watchdog: when a transfer makes count reach MAX_BURST with last=0, go to IDLE, ptr <= locked+1, and o_burstErr pulses high for the next cycle.
- Locked requester drops valid: stay in LOCK (bubbles allowed); no timeout on idle cycles.
- i_rst asserted: o_reqReady=0, o_winc=0, ptr=0, IDLE, count=0, o_burstErr=0.
- Reset mid-burst abandons the lock, and the FIFO keeps any beats already written.

## Timing
- Zero latency: i_reqValid/i_full -> o_reqReady/o_winc/o_wdata are combinational from registered state.
- No combinational path from outputs back to i_full; i_full is registered upstream.
- Sustained throughput is one beat per cycle while not full.
- Full takes effect the cycle after the beat that fills the FIFO, because the write-pointer block updates full on the following edge.
- o_burstErr is registered and high exactly one cycle after the terminating transfer.

## Configuration
- FIFO_WR_ARB_PKT_LOCK_EN defined: IDLE/LOCK FSM, beat counter, watchdog and o_burstErr are present.
- FIFO_WR_ARB_PKT_LOCK_EN undefined: per-beat round-robin only. i_reqLast is unused, and o_burstErr is tied to 0. Port list is identical in both builds.

## Structure
- Package fifo_arb_pkg: state enum typedef {IDLE, LOCK}, and function src_w(n) returning max(1, $clog2(n)).
- Sub-module rr_picker: combinational masked-priority round-robin, inputs req[N_REQ] and ptr, outputs one-hot grant plus index and any. It is used once, with req masked to the locked one-hot in LOCK.

## Test plan
- All 4 valid continuously, i_full=0, per-beat: o_wsrc sequence 0,1,2,3,0,… and o_winc high every cycle.
- Requesters 1 and 3 valid, ptr=2: grant 3 then 1; ptr wraps 3->0 and serves 1.
- i_full=1 for 5 cycles with all valid: o_reqReady=0, o_winc=0, ptr unchanged; grant resumes at the same index the cycle full deasserts.
- Packet lock: req0 sends 3 beats (last on 3rd) while req1 stays valid: 3 consecutive beats with src 0, then src 1.
- Packet lock, MAX_BURST=16: req2 sends 16 beats with last=0: 16 beats accepted, o_burstErr pulses once in the cycle after beat 16, next grant goes to req3 (or the next valid).
- i_rst asserted after 2 beats of a locked burst: outputs 0 during reset; after release, ptr=0 and IDLE, and req0 wins if valid.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Contents: lock_state_t (IDLE/LOCK) and src_w(n) = max(1, $clog2(n)).
// No ports; imported by the interface, picker and top.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } lock_state_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int src_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between N_REQ write-domain requesters and the FIFO write port.
// Requester side: i_reqValid, i_reqData, i_reqLast, plus i_full from the write-pointer block.
// Arbiter side: o_reqReady, o_winc, o_wdata, o_wsrc, o_burstErr.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int SRC_W  = src_w(N_REQ)
);

   logic [N_REQ-1:0]        i_reqValid;
   logic [N_REQ*DATA_W-1:0] i_reqData;
   logic [N_REQ-1:0]        i_reqLast;
   logic                    i_full;
   logic [N_REQ-1:0]        o_reqReady;
   logic                    o_winc;
   logic [DATA_W-1:0]       o_wdata;
   logic [SRC_W-1:0]        o_wsrc;
   logic                    o_burstErr;

   // Requesters and the full-flag source.
   modport master (
      output i_reqValid, i_reqData, i_reqLast, i_full,
      input  o_reqReady, o_winc, o_wdata, o_wsrc, o_burstErr
   );

   // The arbiter.
   modport slave (
      input  i_reqValid, i_reqData, i_reqLast, i_full,
      output o_reqReady, o_winc, o_wdata, o_wsrc, o_burstErr
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
// Ports: req (request vector), ptr (priority start) -> grant (one-hot), idx, any.
// Zero latency, no state.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int SRC_W = src_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [SRC_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [SRC_W-1:0] idx,
   output logic             any
);

   logic [N_REQ-1:0] masked;
   logic [N_REQ-1:0] pool;

   // Requests at or above ptr get first pick; if none, the wrap-around
   // search is simply the lowest set bit of the unmasked vector.
   always_comb begin
      masked = '0;
      for (int i = 0; i < N_REQ; i++) begin
         masked[i] = req[i] && (i >= int'(ptr));
      end
   end

   assign pool = (|masked) ? masked : req;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pool[i] && !any) begin
            grant[i] = 1'b1;
            idx      = SRC_W'(i);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among N_REQ requesters.
// Ports: i_clk, i_rst (async, active-high), arb (slave modport of fifo_wr_arbiter_if).
// Optional packet lock with burst watchdog when FIFO_WR_ARB_PKT_LOCK_EN is defined.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   fifo_wr_arbiter_if.slave arb
);

   localparam int SRC_W = src_w(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   logic [SRC_W-1:0] ptr_q;
   logic [SRC_W-1:0] ptr_d;
   logic [N_REQ-1:0] pick_req;
   logic [N_REQ-1:0] grant;
   logic [SRC_W-1:0] win_idx;
   logic             win_any;
   logic             arb_en;
   logic             xfer;

   function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
      return (int'(i) >= N_REQ - 1) ? '0 : SRC_W'(int'(i) + 1);
   endfunction

   rr_picker #(
      .N_REQ (N_REQ),
      .SRC_W (SRC_W)
   ) u_pick (
      .req   (pick_req),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // Reset also forces the handshake outputs low, not just the state.
   assign arb_en = !i_rst && !arb.i_full;
   // The picker only grants valid requesters, so a winner always transfers.
   assign xfer   = arb_en && win_any;

   assign arb.o_reqReady = xfer ? grant : '0;
   assign arb.o_winc     = xfer;
   assign arb.o_wdata    = arb.i_reqData[int'(win_idx)*DATA_W +: DATA_W];
   assign arb.o_wsrc     = win_idx;

`ifdef FIFO_WR_ARB_PKT_LOCK_EN

   lock_state_t      state_q;
   lock_state_t      state_d;
   logic [SRC_W-1:0] lock_q;
   logic [SRC_W-1:0] lock_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             err_q;
   logic             err_d;
   logic [N_REQ-1:0] lock_mask;
   logic             win_last;

   always_comb begin
      lock_mask         = '0;
      lock_mask[lock_q] = 1'b1;
   end

   // While locked, everyone except the owner is hidden from the picker.
   assign pick_req = (state_q == LOCK) ? (arb.i_reqValid & lock_mask) : arb.i_reqValid;
   assign win_last = arb.i_reqLast[win_idx];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         lock_q  <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      err_d   = 1'b0;
      if (xfer) begin
         unique case (state_q)
            IDLE: begin
               if (win_last) begin
                  ptr_d = next_idx(win_idx);
               end else begin
                  state_d = LOCK;
                  lock_d  = win_idx;
                  cnt_d   = CNT_W'(1);
               end
            end
            LOCK: begin
               if (win_last) begin
                  state_d = IDLE;
                  ptr_d   = next_idx(lock_q);
                  cnt_d   = '0;
               end else if (int'(cnt_q) + 1 >= MAX_BURST) begin
                  // Watchdog: the beat just taken is the last one allowed.
                  state_d = IDLE;
                  ptr_d   = next_idx(lock_q);
                  cnt_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign arb.o_burstErr = err_q;

`else

   assign pick_req = arb.i_reqValid;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = next_idx(win_idx);
      end
   end

   assign arb.o_burstErr = 1'b0;

`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=16).
// Expected beats are queued as stimulus is applied and compared as o_winc fires.
// Packet-lock scenarios are included when FIFO_WR_ARB_PKT_LOCK_EN is defined.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 16;
   localparam int SW = src_w(N);

   logic i_clk = 1'b0;
   logic i_rst;

   always #5 i_clk = ~i_clk;

   fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW), .SRC_W(SW)) arb ();

   fifo_wr_arbiter #(
      .N_REQ     (N),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .arb   (arb)
   );

   int checks = 0;
   int errors = 0;
   logic [SW+DW-1:0] exp_q[$];
   logic [DW-1:0] salt = '0;
   logic          mon_en = 1'b0;

   function automatic logic [DW-1:0] dat_of(input int r);
      return DW'(8'h3C + 8'h11 * r) ^ salt;
   endfunction

   task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] l);
      arb.i_reqValid = v;
      arb.i_reqLast  = l;
      for (int r = 0; r < N; r++) begin
         arb.i_reqData[r*DW +: DW] = dat_of(r);
      end
   endtask

   task automatic push(input int r);
      exp_q.push_back({SW'(r), dat_of(r)});
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic drain_check(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_beats got %0d outstanding need 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic do_reset();
      i_rst      = 1'b1;
      arb.i_full = 1'b0;
      set_in('0, '0);
      run(2);
      i_rst = 1'b0;
   endtask

   // Scoreboard: every accepted beat must match the next queued expectation.
   always @(negedge i_clk) begin
      if (mon_en && !i_rst && arb.o_winc) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got src=%0d dat=%h need no beat", arb.o_wsrc, arb.o_wdata);
         end else begin
            logic [SW+DW-1:0] e;
            e = exp_q.pop_front();
            if ({arb.o_wsrc, arb.o_wdata} !== e) begin
               errors++;
               $display("FAIL beat got src=%0d dat=%h need src=%0d dat=%h",
                        arb.o_wsrc, arb.o_wdata, e[SW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
   end

   task automatic test_reset();
      salt       = 8'h00;
      i_rst      = 1'b1;
      arb.i_full = 1'b0;
      set_in('1, '1);
      #1;
      checks++;
      if (arb.o_reqReady !== '0 || arb.o_winc !== 1'b0 || arb.o_burstErr !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b winc=%b err=%b need 0000 0 0",
                  arb.o_reqReady, arb.o_winc, arb.o_burstErr);
      end
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      #1;
      checks++;
      if (arb.o_reqReady !== 4'b0001 || arb.o_wsrc !== SW'(0) || arb.o_wdata !== dat_of(0)) begin
         errors++;
         $display("FAIL reset_first_grant got rdy=%b src=%0d dat=%h need 0001 0 %h",
                  arb.o_reqReady, arb.o_wsrc, arb.o_wdata, dat_of(0));
      end
      set_in('0, '0);
   endtask

   task automatic test_all_valid();
      salt = 8'h00;
      do_reset();
      set_in('1, '1);
      for (int k = 0; k < 8; k++) push(k % 4);
      run(8);
      set_in('0, '0);
      drain_check("all_valid");
   endtask

   task automatic test_wrap();
      salt = 8'h5A;
      do_reset();
      set_in(4'b0010, '1);
      push(1);
      run(1);
      set_in(4'b1010, '1);
      push(3); push(1); push(3); push(1);
      run(4);
      set_in('0, '0);
      drain_check("wrap");
   endtask

   task automatic test_full();
      salt = 8'hC3;
      do_reset();
      set_in('1, '1);
      push(0);
      run(1);
      arb.i_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (arb.o_reqReady !== '0 || arb.o_winc !== 1'b0) begin
            errors++;
            $display("FAIL full_blocks cycle %0d got rdy=%b winc=%b need 0000 0",
                     k, arb.o_reqReady, arb.o_winc);
         end
         run(1);
      end
      arb.i_full = 1'b0;
      #1;
      checks++;
      if (arb.o_reqReady !== 4'b0010 || arb.o_wsrc !== SW'(1) || arb.o_winc !== 1'b1) begin
         errors++;
         $display("FAIL full_resume got rdy=%b src=%0d winc=%b need 0010 1 1",
                  arb.o_reqReady, arb.o_wsrc, arb.o_winc);
      end
      push(1); push(2);
      run(2);
      set_in('0, '0);
      drain_check("full");
   endtask

   // Reset during a multi-beat transfer of requester 2; afterwards req0 must win.
   task automatic test_reset_mid_burst();
      salt = 8'hE1;
      do_reset();
      set_in(4'b0100, 4'b0000);
      push(2); push(2);
      run(2);
      drain_check("pre_reset");
      i_rst = 1'b1;
      set_in(4'b0101, 4'b0000);
      #1;
      checks++;
      if (arb.o_reqReady !== '0 || arb.o_winc !== 1'b0 || arb.o_burstErr !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs got rdy=%b winc=%b err=%b need 0000 0 0",
                  arb.o_reqReady, arb.o_winc, arb.o_burstErr);
      end
      run(2);
      i_rst = 1'b0;
      set_in(4'b0101, 4'b0101);
      #1;
      checks++;
      if (arb.o_reqReady !== 4'b0001 || arb.o_wsrc !== SW'(0)) begin
         errors++;
         $display("FAIL midreset_regrant got rdy=%b src=%0d need 0001 0",
                  arb.o_reqReady, arb.o_wsrc);
      end
      push(0);
      run(1);
      set_in('0, '0);
      drain_check("midreset");
   endtask

`ifdef FIFO_WR_ARB_PKT_LOCK_EN

   task automatic test_pkt_lock();
      salt = 8'h77;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_in(4'b0011, {2'b00, 1'b1, (k == 2)});
         push(0);
         #1;
         checks++;
         if (arb.o_reqReady !== 4'b0001) begin
            errors++;
            $display("FAIL lock_hold beat %0d got rdy=%b need 0001", k, arb.o_reqReady);
         end
         run(1);
      end
      set_in(4'b0010, 4'b0010);
      push(1);
      run(1);
      set_in('0, '0);
      drain_check("pkt_lock");
   endtask

   task automatic test_watchdog();
      salt = 8'h19;
      do_reset();
      set_in(4'b1100, 4'b1000);
      for (int k = 0; k < MB; k++) begin
         push(2);
         #1;
         checks++;
         if (arb.o_burstErr !== 1'b0 || arb.o_reqReady !== 4'b0100) begin
            errors++;
            $display("FAIL wd_burst beat %0d got err=%b rdy=%b need 0 0100",
                     k, arb.o_burstErr, arb.o_reqReady);
         end
         run(1);
      end
      push(3);
      #1;
      checks++;
      if (arb.o_burstErr !== 1'b1 || arb.o_wsrc !== SW'(3) || arb.o_reqReady !== 4'b1000) begin
         errors++;
         $display("FAIL wd_terminate got err=%b src=%0d rdy=%b need 1 3 1000",
                  arb.o_burstErr, arb.o_wsrc, arb.o_reqReady);
      end
      run(1);
      set_in('0, '0);
      #1;
      checks++;
      if (arb.o_burstErr !== 1'b0) begin
         errors++;
         $display("FAIL wd_pulse_width got err=%b need 0", arb.o_burstErr);
      end
      drain_check("watchdog");
   endtask

`else

   task automatic test_last_ignored();
      salt = 8'h42;
      do_reset();
      set_in('1, '0);
      for (int k = 0; k < 6; k++) begin
         push(k % 4);
         #1;
         checks++;
         if (arb.o_burstErr !== 1'b0) begin
            errors++;
            $display("FAIL no_lock_err cycle %0d got err=%b need 0", k, arb.o_burstErr);
         end
         run(1);
      end
      set_in('0, '0);
      drain_check("last_ignored");
   endtask

`endif

   initial begin
      #100000;
      $display("FAIL timeout simulation did not finish need finish");
      $fatal(1);
   end

   initial begin
      i_rst      = 1'b1;
      arb.i_full = 1'b0;
      set_in('0, '0);
      mon_en = 1'b1;
      test_reset();
      test_all_valid();
      test_wrap();
      test_full();
      test_reset_mid_burst();
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
      test_pkt_lock();
      test_watchdog();
`else
      test_last_ignored();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
